enigma_rotor_stage: RTL and testbench

- Parametrised, clocked Enigma rotor stage; a scrambler chain instantiates one stage per wheel between the plugboard and the reflector.
- Holds rotor position and ring setting, steps on keystrokes using notch carry, and substitutes letters in forward or reverse direction.
- Output is registered with a valid flag.

---
 rtl/enigma_rotor_stage_if.sv | 28 ++
 rtl/enigma_rotor_stage.sv | 181 ++++++++++++++++++
 tb/tb_enigma_rotor_stage.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_rotor_stage_if.sv
// ---------------------------------------------------------------------------
// enigma_rotor_stage_if
//   Letter request / response bundle of one Enigma rotor stage.
//   master (scrambler chain side): drives in_valid, dir, letter_in and
//                                  receives out_valid, letter_out, err.
//   slave  (rotor stage side)    : the opposite directions.
//   Parameter W : letter width.
// ---------------------------------------------------------------------------
interface enigma_rotor_stage_if #(
  parameter int W = 5
);
  logic         in_valid;
  logic         dir;
  logic [W-1:0] letter_in;
  logic         out_valid;
  logic [W-1:0] letter_out;
  logic         err;

  modport master (
    output in_valid, dir, letter_in,
    input  out_valid, letter_out, err
  );

  modport slave (
    input  in_valid, dir, letter_in,
    output out_valid, letter_out, err
  );
endinterface

// File: rtl/enigma_rotor_stage.sv
// ---------------------------------------------------------------------------
// enigma_rotor_stage
//   One clocked Enigma wheel: holds position and ring setting, steps on a
//   keystroke (notch carry from the next-faster wheel, or always when FAST),
//   and substitutes one letter per request, forward or reverse, with a
//   registered one-cycle-latency result.
//
// Ports
//   clk, rst    system clock, synchronous active-high reset
//   key_press   one-cycle keystroke pulse (broadcast to every stage)
//   step_in     notch_out of the next-faster stage
//   notch_out   combinational, high while pos sits on the notch letter
//   cfg_load    load cfg_pos / cfg_ring (out-of-range values load 0)
//   cfg_pos     start position
//   cfg_ring    ring setting
//   pos         current position, for the display
//   bus         slave side of enigma_rotor_stage_if:
//                 in_valid/dir/letter_in request,
//                 out_valid/letter_out/err registered response
//
// Optional feature
//   ROTOR_DOUBLE_STEP_EN : when defined and MIDDLE=1 the wheel also steps off
//   its own notch, which gives the historical middle-wheel double step.
// ---------------------------------------------------------------------------
module enigma_rotor_stage #(
  parameter int ALPHA     = 26,
  parameter int W         = 5,
  parameter int ROTOR_SEL = 0,
  parameter int FAST      = 0,
  parameter int MIDDLE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_press,
  input  logic                 step_in,
  output logic                 notch_out,
  input  logic                 cfg_load,
  input  logic [W-1:0]         cfg_pos,
  input  logic [W-1:0]         cfg_ring,
  output logic [W-1:0]         pos,
  enigma_rotor_stage_if.slave  bus
);

  localparam logic [W:0]   ALPHA_X  = (W+1)'(ALPHA);
  localparam logic [W-1:0] ALPHA_M1 = W'(ALPHA - 1);

  localparam int NOTCH = (ROTOR_SEL == 0) ? 16 :
                         (ROTOR_SEL == 1) ? 4  :
                         (ROTOR_SEL == 2) ? 21 : ALPHA - 1;

  // Historical wirings I, II, III as letter indices (A=0).
  localparam logic [4:0] WIRE_I [26] = '{
    5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21,
    5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20,
    5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
  localparam logic [4:0] WIRE_II [26] = '{
    5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23,
    5'd1,  5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,
    5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
  localparam logic [4:0] WIRE_III [26] = '{
    5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17,
    5'd19, 5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd8,  5'd22,
    5'd6,  5'd0,  5'd10, 5'd12, 5'd14, 5'd20, 5'd16, 5'd18};

  // Forward wiring. Inputs outside the alphabet map to 0; they only occur
  // on error requests whose result is discarded.
  function automatic logic [W-1:0] wire_fwd(input logic [W-1:0] s);
    logic [4:0]   idx;
    logic [W-1:0] r;
    idx = 5'(s);
    r   = '0;
    if ({1'b0, s} < ALPHA_X) begin
      case (ROTOR_SEL)
        0:       r = W'(WIRE_I[idx]);
        1:       r = W'(WIRE_II[idx]);
        2:       r = W'(WIRE_III[idx]);
        default: r = (s == ALPHA_M1) ? '0 : s + W'(1);
      endcase
    end
    return r;
  endfunction

  // Reverse wiring. For the table rotors the inverse is found by matching
  // every forward entry against s, so only one table has to be maintained.
  function automatic logic [W-1:0] wire_inv(input logic [W-1:0] s);
    logic [W-1:0] r;
    r = '0;
    if (ROTOR_SEL > 2) begin
      r = (s == '0) ? ALPHA_M1 : s - W'(1);
    end else begin
      for (int i = 0; i < ALPHA; i++) begin
        if (wire_fwd(W'(i)) == s) r = W'(i);
      end
    end
    return r;
  endfunction

  logic [W-1:0] ring;
  logic         out_valid_q;
  logic [W-1:0] letter_out_q;
  logic         err_q;

  logic         step_cond;
  logic         letter_bad;
  logic [W-1:0] cfg_pos_ok;
  logic [W-1:0] cfg_ring_ok;

  logic [W:0]   sum_a, a_mod, s_mod;
  logic [W-1:0] s_let, t_let;
  logic [W:0]   u_raw, u_mod, v_raw, v_mod;
  logic [W-1:0] sub_letter;

  assign notch_out = (pos == W'(NOTCH));

`ifdef ROTOR_DOUBLE_STEP_EN
  assign step_cond = (FAST != 0) || step_in || ((MIDDLE != 0) && notch_out);
`else
  logic unused_middle;
  assign unused_middle = (MIDDLE != 0);
  assign step_cond     = (FAST != 0) || step_in;
`endif

  assign letter_bad  = ({1'b0, bus.letter_in} >= ALPHA_X);
  assign cfg_pos_ok  = ({1'b0, cfg_pos}  < ALPHA_X) ? cfg_pos  : '0;
  assign cfg_ring_ok = ({1'b0, cfg_ring} < ALPHA_X) ? cfg_ring : '0;

  // Contact offset arithmetic: every add/subtract is brought back into
  // range with a single +/-ALPHA correction on a W+1-bit intermediate.
  always_comb begin
    sum_a = {1'b0, bus.letter_in} + {1'b0, pos};
    a_mod = (sum_a >= ALPHA_X) ? sum_a - ALPHA_X : sum_a;
    s_mod = (a_mod >= {1'b0, ring}) ? a_mod - {1'b0, ring}
                                    : a_mod + ALPHA_X - {1'b0, ring};
    s_let = s_mod[W-1:0];

    t_let = bus.dir ? wire_inv(s_let) : wire_fwd(s_let);

    u_raw = {1'b0, t_let} - {1'b0, pos};
    u_mod = (t_let < pos) ? u_raw + ALPHA_X : u_raw;
    v_raw = u_mod + {1'b0, ring};
    v_mod = (v_raw >= ALPHA_X) ? v_raw - ALPHA_X : v_raw;
    sub_letter = v_mod[W-1:0];
  end

  logic unused_hi;
  assign unused_hi = s_mod[W] ^ v_mod[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      pos          <= '0;
      ring         <= '0;
      out_valid_q  <= 1'b0;
      letter_out_q <= '0;
      err_q        <= 1'b0;
    end else begin
      // A keystroke coinciding with a configuration load is dropped.
      if (cfg_load) begin
        pos  <= cfg_pos_ok;
        ring <= cfg_ring_ok;
      end else if (key_press && step_cond) begin
        pos <= (pos == ALPHA_M1) ? '0 : pos + W'(1);
      end

      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        if (letter_bad) begin
          letter_out_q <= '0;
          err_q        <= 1'b1;
        end else begin
          letter_out_q <= sub_letter;
          err_q        <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.letter_out = letter_out_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
module tb_enigma_rotor_stage;
  localparam int W = 5;

`ifdef ROTOR_DOUBLE_STEP_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       = 1'b1;
  logic         key_press = 1'b0;
  logic         step1     = 1'b0;
  logic [2:0]   cfg_load  = 3'b000;
  logic [W-1:0] cfg_pos   = '0;
  logic [W-1:0] cfg_ring  = '0;
  logic         in_valid  = 1'b0;
  logic         dir       = 1'b0;
  logic [W-1:0] letter_in = '0;

  logic         notch0, notch1, notch2;
  logic [W-1:0] pos0, pos1, pos2;

  enigma_rotor_stage_if #(.W(W)) bus0 ();
  enigma_rotor_stage_if #(.W(W)) bus1 ();
  enigma_rotor_stage_if #(.W(W)) bus2 ();

  assign bus0.in_valid = in_valid;  assign bus0.dir = dir;  assign bus0.letter_in = letter_in;
  assign bus1.in_valid = in_valid;  assign bus1.dir = dir;  assign bus1.letter_in = letter_in;
  assign bus2.in_valid = in_valid;  assign bus2.dir = dir;  assign bus2.letter_in = letter_in;

  // Stage 0: rotor I, fast wheel. Stage 1: rotor II, middle wheel.
  // Stage 2: shift-by-one wiring over 20 letters, carried by stage 0's notch.
  enigma_rotor_stage #(.ALPHA(26), .W(W), .ROTOR_SEL(0), .FAST(1), .MIDDLE(0)) u0 (
    .clk(clk), .rst(rst), .key_press(key_press), .step_in(1'b0), .notch_out(notch0),
    .cfg_load(cfg_load[0]), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring), .pos(pos0), .bus(bus0));
  enigma_rotor_stage #(.ALPHA(26), .W(W), .ROTOR_SEL(1), .FAST(0), .MIDDLE(1)) u1 (
    .clk(clk), .rst(rst), .key_press(key_press), .step_in(step1), .notch_out(notch1),
    .cfg_load(cfg_load[1]), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring), .pos(pos1), .bus(bus1));
  enigma_rotor_stage #(.ALPHA(20), .W(W), .ROTOR_SEL(3), .FAST(0), .MIDDLE(0)) u2 (
    .clk(clk), .rst(rst), .key_press(key_press), .step_in(notch0), .notch_out(notch2),
    .cfg_load(cfg_load[2]), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring), .pos(pos2), .bus(bus2));

  int d_pos [3], d_lo [3], d_ov [3], d_err [3], d_notch [3];
  always_comb begin
    d_pos[0] = int'(pos0); d_pos[1] = int'(pos1); d_pos[2] = int'(pos2);
    d_notch[0] = int'(notch0); d_notch[1] = int'(notch1); d_notch[2] = int'(notch2);
    d_lo[0] = int'(bus0.letter_out); d_lo[1] = int'(bus1.letter_out); d_lo[2] = int'(bus2.letter_out);
    d_ov[0] = int'(bus0.out_valid); d_ov[1] = int'(bus1.out_valid); d_ov[2] = int'(bus2.out_valid);
    d_err[0] = int'(bus0.err); d_err[1] = int'(bus1.err); d_err[2] = int'(bus2.err);
  end

  // ---------------- behavioural model ----------------
  int    m_sel   [3] = '{0, 1, 3};
  int    m_alpha [3] = '{26, 26, 20};
  int    m_fast  [3] = '{1, 0, 0};
  int    m_mid   [3] = '{0, 1, 0};
  string wires   [3] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ",
                         "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                         "BDFHJLCPRTXVZNYEIWGAKMOUQS"};
  string notch_letters = "QEV";

  int m_pos [3], m_ring [3], m_lo [3], m_ov [3], m_err [3];
  bit live = 1'b0;

  function automatic int fwd(int k, int s);
    if (m_sel[k] == 3) return (s + 1) % m_alpha[k];
    return int'(wires[m_sel[k]].getc(s)) - 65;
  endfunction

  function automatic int inv(int k, int s);
    if (m_sel[k] == 3) return (s + m_alpha[k] - 1) % m_alpha[k];
    for (int j = 0; j < 26; j++)
      if (int'(wires[m_sel[k]].getc(j)) - 65 == s) return j;
    return -1;
  endfunction

  function automatic int notch_of(int k);
    if (m_sel[k] == 3) return m_alpha[k] - 1;
    return int'(notch_letters.getc(m_sel[k])) - 65;
  endfunction

  function automatic int subst(int k, int l, int p, int r, bit d);
    int a, s, t;
    a = m_alpha[k];
    s = (l + p - r + 2 * a) % a;
    t = d ? inv(k, s) : fwd(k, s);
    return (t - p + r + 2 * a) % a;
  endfunction

  always @(posedge clk) begin
    bit nt [3];
    bit stp;
    for (int k = 0; k < 3; k++) nt[k] = (m_pos[k] == notch_of(k));
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_pos[k] = 0; m_ring[k] = 0; m_lo[k] = 0; m_ov[k] = 0; m_err[k] = 0;
      end else begin
        m_ov[k] = int'(in_valid);
        if (in_valid) begin
          if (int'(letter_in) >= m_alpha[k]) begin
            m_lo[k] = 0; m_err[k] = 1;
          end else begin
            m_lo[k] = subst(k, int'(letter_in), m_pos[k], m_ring[k], dir);
            m_err[k] = 0;
          end
        end
        stp = (m_fast[k] != 0) || (k == 1 && step1) || (k == 2 && nt[0])
              || (DS && m_mid[k] != 0 && nt[k]);
        if (cfg_load[k]) begin
          m_pos[k]  = (int'(cfg_pos)  < m_alpha[k]) ? int'(cfg_pos)  : 0;
          m_ring[k] = (int'(cfg_ring) < m_alpha[k]) ? int'(cfg_ring) : 0;
        end else if (key_press && stp) begin
          m_pos[k] = (m_pos[k] + 1) % m_alpha[k];
        end
      end
    end
    if (rst) live = 1'b1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, int k, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s stage%0d at %0t: got %0d, expected %0d", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < 3; k++) begin
        chk("pos", k, d_pos[k], m_pos[k]);
        chk("notch_out", k, d_notch[k], int'(m_pos[k] == notch_of(k)));
        chk("out_valid", k, d_ov[k], m_ov[k]);
        chk("letter_out", k, d_lo[k], m_lo[k]);
        chk("err", k, d_err[k], m_err[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("reset_pos", 0, d_pos[0], 0);
    chk("reset_ov", 0, d_ov[0], 0);
    chk("reset_lo", 0, d_lo[0], 0);
    chk("reset_err", 0, d_err[0], 0);

    // A through rotor I at pos 0 / ring 0 gives E
    in_valid = 1'b1; dir = 1'b0; letter_in = 5'd0;
    tick();
    in_valid = 1'b0;
    chk("fwd_A_to_E", 0, d_lo[0], 4);
    chk("ov_one_cycle_hi", 0, d_ov[0], 1);
    chk("fwd_A_rotorII", 1, d_lo[1], 0);
    chk("fwd_A_shift20", 2, d_lo[2], 1);
    tick();
    chk("ov_one_cycle_lo", 0, d_ov[0], 0);
    chk("lo_holds", 0, d_lo[0], 4);

    // fast wheel steps, then A -> J and reverse J -> A
    key_press = 1'b1;
    tick();
    key_press = 1'b0;
    chk("fast_step", 0, d_pos[0], 1);
    chk("slow_no_step", 1, d_pos[1], 0);
    in_valid = 1'b1; dir = 1'b0; letter_in = 5'd0;
    tick();
    chk("fwd_A_pos1", 0, d_lo[0], 9);
    dir = 1'b1; letter_in = 5'd9;
    tick();
    in_valid = 1'b0;
    chk("rev_J_pos1", 0, d_lo[0], 0);

    // ring B
    cfg_pos = 5'd0; cfg_ring = 5'd1; cfg_load = 3'b001;
    tick();
    cfg_load = 3'b000;
    in_valid = 1'b1; dir = 1'b0; letter_in = 5'd0;
    tick();
    in_valid = 1'b0;
    chk("ring_B_A_to_K", 0, d_lo[0], 10);

    // notch, carry into stage 2, and wrap
    cfg_pos = 5'd16; cfg_ring = 5'd0; cfg_load = 3'b001;
    tick();
    cfg_load = 3'b000;
    chk("notch_on_Q", 0, d_notch[0], 1);
    key_press = 1'b1;
    tick();
    key_press = 1'b0;
    chk("step_off_notch", 0, d_pos[0], 17);
    chk("notch_off", 0, d_notch[0], 0);
    chk("carry_step", 2, d_pos[2], 1);
    cfg_pos = 5'd25; cfg_load = 3'b001;
    tick();
    cfg_load = 3'b000;
    key_press = 1'b1;
    tick();
    key_press = 1'b0;
    chk("wrap_to_0", 0, d_pos[0], 0);

    // load beats keystroke; out-of-range load gives 0
    cfg_pos = 5'd3; cfg_load = 3'b001; key_press = 1'b1;
    tick();
    key_press = 1'b0;
    chk("cfg_drops_key", 0, d_pos[0], 3);
    cfg_pos = 5'd30; cfg_ring = 5'd28;
    tick();
    cfg_load = 3'b000;
    chk("cfg_out_of_range", 0, d_pos[0], 0);

    // middle wheel sitting on its own notch
    cfg_pos = 5'd4; cfg_ring = 5'd0; cfg_load = 3'b010;
    tick();
    cfg_load = 3'b000;
    key_press = 1'b1; step1 = 1'b0;
    tick();
    key_press = 1'b0;
    chk("double_step", 1, d_pos[1], DS ? 5 : 4);
    key_press = 1'b1; step1 = 1'b1;
    tick();
    key_press = 1'b0; step1 = 1'b0;
    chk("step_in_carry", 1, d_pos[1], DS ? 6 : 5);

    // illegal letter
    in_valid = 1'b1; letter_in = 5'd27;
    tick();
    in_valid = 1'b0;
    chk("err_set", 0, d_err[0], 1);
    chk("err_letter_zero", 0, d_lo[0], 0);
    chk("err_ov", 0, d_ov[0], 1);
    tick();
    chk("err_holds_idle", 0, d_err[0], 1);
    in_valid = 1'b1; letter_in = 5'd0;
    tick();
    in_valid = 1'b0;
    chk("err_clears", 0, d_err[0], 0);

    // directed sweep: mixed directions, keystrokes, carries and a few illegal letters
    for (int i = 0; i < 60; i++) begin
      in_valid  = (i % 5 != 4);
      dir       = i[0];
      letter_in = W'((i * 7) % 32);
      key_press = (i % 3 == 0);
      step1     = (i % 4 == 0);
      cfg_pos   = W'(i % 26);
      cfg_ring  = W'((i * 3) % 26);
      cfg_load  = (i % 17 == 8) ? 3'b111 : 3'b000;
      tick();
    end
    in_valid = 1'b0; key_press = 1'b0; step1 = 1'b0; cfg_load = 3'b000;
    tick();

    // reset wins over keystroke and request
    rst = 1'b1; key_press = 1'b1; in_valid = 1'b1; letter_in = 5'd5;
    tick();
    rst = 1'b0; key_press = 1'b0; in_valid = 1'b0;
    chk("rst_over_pos", 0, d_pos[0], 0);
    chk("rst_over_ov", 0, d_ov[0], 0);
    chk("rst_over_lo", 0, d_lo[0], 0);
    chk("rst_over_err", 0, d_err[0], 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
